gmii2fifo_param: RTL

GMII2FIFO_PARAM -- requirements
Module: gmii2fifo_param

---
 rtl/gmii_rx_pkg.sv | 57 +++++
 rtl/gmii_udp_hdr_filter.sv | 55 +++++
 rtl/gmii2fifo_param.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/gmii_rx_pkg.sv
// Shared constants for the GMII UDP video receiver: header byte offsets,
// packet type codes, protocol constants, captured-field struct, FSM encoding.
package gmii_rx_pkg;

   localparam int CNT_W = 16;

   // Frame byte offsets; offset 0 is the first preamble byte
   localparam logic [CNT_W-1:0] OFS_ETH_TYPE = 16'd20;
   localparam logic [CNT_W-1:0] OFS_IP_VER   = 16'd22;
   localparam logic [CNT_W-1:0] OFS_PROTO    = 16'd31;
   localparam logic [CNT_W-1:0] OFS_IPV4_DST = 16'd38;
   localparam logic [CNT_W-1:0] OFS_DST_PORT = 16'd44;
   localparam logic [CNT_W-1:0] OFS_UDP_LEN  = 16'd46;
   localparam logic [CNT_W-1:0] OFS_TYPE     = 16'd50;
   localparam logic [CNT_W-1:0] OFS_Y_LO     = 16'd51;
   localparam logic [CNT_W-1:0] OFS_YX       = 16'd52;

   // Packet type codes carried in the first UDP payload byte
   localparam logic [7:0] TYPE_VIDEO     = 8'h00;
   localparam logic [7:0] TYPE_AUDIO     = 8'h01;
   localparam logic [7:0] TYPE_VIDEO_AUX = 8'h02;

   // Header values a frame must carry to be considered
   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_VER_IHL    = 8'h45;
   localparam logic [7:0]  PROTO_UDP     = 8'h11;

   // UDP header (8) + type byte + two y/x bytes precede any aux/pixel data
   localparam logic [15:0] UDP_FIXED_BYTES = 16'd11;

   typedef struct packed {
      logic [15:0] eth_type;
      logic [7:0]  ip_ver;
      logic [7:0]  proto;
      logic [31:0] ipv4_dst;
      logic [15:0] dst_port;
      logic [15:0] udp_len;
   } hdr_fields_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      VIDEO = 3'd2,
      AUX   = 3'd3,
      DROP  = 3'd4
   } state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // a - b, floored at zero
   function automatic logic [15:0] sub_floor(input logic [15:0] a, input logic [15:0] b);
      return (a > b) ? a - b : 16'd0;
   endfunction

endpackage

// File: rtl/gmii_udp_hdr_filter.sv
// Captures the Ethernet/IPv4/UDP header fields from the byte stream and
// compares them against the selected channel's address and port.
module gmii_udp_hdr_filter
   import gmii_rx_pkg::*;
#(
   parameter logic [31:0] IPV4_DST_BASE = 32'hC0A8_0001,
   parameter logic [15:0] DST_PORT      = 16'd12345,
   parameter int          NUM_ID        = 2,
   parameter int          IDW           = 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_dv,
   input  logic [7:0]       rxd,
   input  logic [CNT_W-1:0] cnt,
   input  logic [IDW-1:0]   id,
   output logic             match,
   output hdr_fields_t      hdr
);

   logic id_ok;

   // Big-endian capture of each field at its fixed offset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hdr <= '0;
      end else if (rx_dv) begin
         case (cnt)
            OFS_ETH_TYPE:          hdr.eth_type[15:8]  <= rxd;
            OFS_ETH_TYPE + 16'd1:  hdr.eth_type[7:0]   <= rxd;
            OFS_IP_VER:            hdr.ip_ver          <= rxd;
            OFS_PROTO:             hdr.proto           <= rxd;
            OFS_IPV4_DST:          hdr.ipv4_dst[31:24] <= rxd;
            OFS_IPV4_DST + 16'd1:  hdr.ipv4_dst[23:16] <= rxd;
            OFS_IPV4_DST + 16'd2:  hdr.ipv4_dst[15:8]  <= rxd;
            OFS_IPV4_DST + 16'd3:  hdr.ipv4_dst[7:0]   <= rxd;
            OFS_DST_PORT:          hdr.dst_port[15:8]  <= rxd;
            OFS_DST_PORT + 16'd1:  hdr.dst_port[7:0]   <= rxd;
            OFS_UDP_LEN:           hdr.udp_len[15:8]   <= rxd;
            OFS_UDP_LEN + 16'd1:   hdr.udp_len[7:0]    <= rxd;
            default: ;
         endcase
      end
   end

   // id is compared live so the channel select is taken at the type byte
   assign id_ok = (int'(id) < NUM_ID);
   assign match = (hdr.eth_type == ETH_TYPE_IPV4) &&
                  (hdr.ip_ver   == IP_VER_IHL)    &&
                  (hdr.proto    == PROTO_UDP)     &&
                  id_ok                           &&
                  (hdr.ipv4_dst == IPV4_DST_BASE + 32'(id)) &&
                  (hdr.dst_port == DST_PORT);

endmodule

// File: rtl/gmii2fifo_param.sv
// GMII receiver that filters UDP video/audio packets for one channel and
// emits assembled video words plus an aux byte stream.
// Strobes recv_en / aux_wr_en are single-cycle write enables with the data
// valid in the same cycle; there is no back-pressure.
module gmii2fifo_param
   import gmii_rx_pkg::*;
#(
   parameter logic [31:0] IPV4_DST_BASE = 32'hC0A8_0001,
   parameter logic [15:0] DST_PORT      = 16'd12345,
   parameter int          NUM_ID        = 2,
   parameter int          PIX_BYTES     = 2,
   parameter int          VID_BYTES     = 1200,
   parameter int          IDW           = (NUM_ID > 1) ? $clog2(NUM_ID) : 1
)(
   input  logic                       clk125,
   input  logic                       sys_rst,
   input  logic [IDW-1:0]             id,
   input  logic [7:0]                 rxd,
   input  logic                       rx_dv,
   output logic [16+8*PIX_BYTES-1:0]  datain,
   output logic                       recv_en,
   output logic                       packet_en,
   output logic [7:0]                 aux_data_in,
   output logic                       aux_wr_en,
   output logic                       pkt_drop,
   output logic [15:0]                pkt_cnt,
   output logic [15:0]                drop_cnt,
   output state_t                     fsm_state
);

   localparam int          PSR_W          = 8*PIX_BYTES - 8;
   localparam logic [15:0] VID_LAST       = 16'(VID_BYTES - 1);
   localparam logic [15:0] AUX_SKIP_VIDEO = UDP_FIXED_BYTES + 16'(VID_BYTES);
   localparam logic [1:0]  WORD_LAST      = 2'(PIX_BYTES - 1);

   logic [CNT_W-1:0] cnt;
   logic             armed;
   state_t           state;
   logic [7:0]       ptype;
   logic [11:0]      y;
   logic [3:0]       x;
   logic [PSR_W-1:0] pix_sr;
   logic [1:0]       byte_idx;
   logic [15:0]      pix_cnt;
   logic [15:0]      aux_rem;
   logic             hdr_match;
   hdr_fields_t      hdr;
   logic             unused_hdr;

   gmii_udp_hdr_filter #(
      .IPV4_DST_BASE (IPV4_DST_BASE),
      .DST_PORT      (DST_PORT),
      .NUM_ID        (NUM_ID),
      .IDW           (IDW)
   ) u_filter (
      .clk   (clk125),
      .rst   (sys_rst),
      .rx_dv (rx_dv),
      .rxd   (rxd),
      .cnt   (cnt),
      .id    (id),
      .match (hdr_match),
      .hdr   (hdr)
   );

   // Only udp_len is needed here; the rest feeds the match flag inside the filter
   assign unused_hdr = ^{hdr.eth_type, hdr.ip_ver, hdr.proto, hdr.ipv4_dst, hdr.dst_port};

   // Frame byte offset: zero between frames, saturates on very long frames
   always_ff @(posedge clk125 or posedge sys_rst) begin
      if (sys_rst)          cnt <= '0;
      else if (!rx_dv)      cnt <= '0;
      else if (cnt != '1)   cnt <= cnt + 1'b1;
   end

   // Receive FSM with registered strobes, word assembly and packet counters
   always_ff @(posedge clk125 or posedge sys_rst) begin
      if (sys_rst) begin
         state       <= IDLE;
         armed       <= 1'b0;
         ptype       <= '0;
         y           <= '0;
         x           <= '0;
         pix_sr      <= '0;
         byte_idx    <= '0;
         pix_cnt     <= '0;
         aux_rem     <= '0;
         datain      <= '0;
         recv_en     <= 1'b0;
         aux_data_in <= '0;
         aux_wr_en   <= 1'b0;
         pkt_drop    <= 1'b0;
         pkt_cnt     <= '0;
         drop_cnt    <= '0;
      end else begin
         recv_en   <= 1'b0;
         aux_wr_en <= 1'b0;
         pkt_drop  <= 1'b0;
         // After reset, wait for a gap so a half-received frame is not parsed
         if (!rx_dv) armed <= 1'b1;

         case (state)
            IDLE: begin
               byte_idx <= '0;
               pix_cnt  <= '0;
               if (rx_dv && armed && (cnt == '0)) state <= HDR;
            end

            HDR: begin
               if (!rx_dv) begin
                  state <= IDLE;
               end else if (cnt == OFS_TYPE) begin
                  ptype <= rxd;
                  if (!hdr_match) begin
                     state <= DROP;
                  end else begin
                     case (rxd)
                        TYPE_VIDEO, TYPE_VIDEO_AUX: begin
                           state   <= VIDEO;
                           pkt_cnt <= sat_inc16(pkt_cnt);
                           aux_rem <= sub_floor(hdr.udp_len, AUX_SKIP_VIDEO);
                        end
                        TYPE_AUDIO: begin
                           state   <= AUX;
                           pkt_cnt <= sat_inc16(pkt_cnt);
                           aux_rem <= sub_floor(hdr.udp_len, UDP_FIXED_BYTES);
                        end
                        default: state <= DROP;
                     endcase
                  end
               end
            end

            VIDEO: begin
               if (!rx_dv) begin
                  // Truncated: any partial word is simply abandoned
                  state    <= IDLE;
                  pkt_drop <= 1'b1;
                  drop_cnt <= sat_inc16(drop_cnt);
               end else if (cnt == OFS_Y_LO) begin
                  y[7:0] <= rxd;
               end else if (cnt == OFS_YX) begin
                  y[11:8] <= rxd[3:0];
                  x       <= rxd[7:4];
               end else begin
                  pix_sr  <= PSR_W'({pix_sr, rxd});
                  pix_cnt <= pix_cnt + 16'd1;
                  if (byte_idx == WORD_LAST) begin
                     byte_idx <= '0;
                     datain   <= {y, x, pix_sr, rxd};
                     recv_en  <= 1'b1;
                  end else begin
                     byte_idx <= byte_idx + 2'd1;
                  end
                  if (pix_cnt == VID_LAST)
                     state <= (ptype == TYPE_VIDEO_AUX) ? AUX : IDLE;
               end
            end

            AUX: begin
               if (!rx_dv) begin
                  state <= IDLE;
               end else if (aux_rem == '0) begin
                  state <= DROP;
               end else begin
                  aux_wr_en   <= 1'b1;
                  aux_data_in <= rxd;
                  aux_rem     <= aux_rem - 16'd1;
                  if (aux_rem == 16'd1) state <= DROP;
               end
            end

            DROP: begin
               if (!rx_dv) state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign packet_en = (state == VIDEO);
   assign fsm_state = state;

endmodule
